// File: rtl/riscv_opcodes_pkg.sv
// Shared RV32I types: register index, the x0 constant and the operand
// forwarding source encoding used by the ID operand-fetch stage.
package riscv_opcodes_pkg;

  typedef logic [4:0] rsd_t;

  localparam rsd_t zero = 5'd0;

  // Number of source operands fetched per instruction (rs1, rs2)
  localparam int NUM_OPS = 2;

  // Which source an operand was taken from; kept visible for debug/coverage
  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_SHADOW,
    FWD_RF
  } fwd_sel_e;

endpackage

// File: rtl/riscv_operand_mux.sv
// One source operand: held index/use bit, a shadow of WB data that lands
// while the instruction waits in ID, and the bypass priority select.
module riscv_operand_mux
  import riscv_opcodes_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_i,
  input  rsd_t            src_i,
  input  logic            use_i,
  input  logic            ex_fwd_i,
  input  rsd_t            ex_dst_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            mem_we_i,
  input  rsd_t            mem_dst_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            rf_we_i,
  input  rsd_t            rf_dst_i,
  input  logic [XLEN-1:0] rf_dst_d_i,
  input  logic [XLEN-1:0] rf_q_i,
  output rsd_t            src_o,
  output logic            use_o,
  output logic [XLEN-1:0] op_o
);

  rsd_t            src_q;
  logic            use_q;
  logic            sh_vld;
  logic [XLEN-1:0] sh_data;
  fwd_sel_e        sel;

  // WB hit against the index being loaded this edge (sample) or the held one
  logic wb_new_hit, wb_held_hit;
  assign wb_new_hit  = rf_we_i && (rf_dst_i == src_i) && (src_i != zero);
  assign wb_held_hit = rf_we_i && (rf_dst_i == src_q) && (src_q != zero);

  // Index/use capture and shadow tracking; a newer WB write overwrites the shadow
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q   <= zero;
      use_q   <= 1'b0;
      sh_vld  <= 1'b0;
      sh_data <= '0;
    end else if (sample_i) begin
      src_q  <= src_i;
      use_q  <= use_i;
      sh_vld <= wb_new_hit;
      if (wb_new_hit) sh_data <= rf_dst_d_i;
    end else if (wb_held_hit) begin
      sh_vld  <= 1'b1;
      sh_data <= rf_dst_d_i;
    end
  end

  // Forwarding priority: x0, EX (non-load), MEM, WB, shadow, RF read data
  always_comb begin
    sel = FWD_RF;
    if (src_q == zero)                            sel = FWD_ZERO;
    else if (ex_fwd_i && (ex_dst_i == src_q))     sel = FWD_EX;
    else if (mem_we_i && (mem_dst_i == src_q))    sel = FWD_MEM;
    else if (rf_we_i && (rf_dst_i == src_q))      sel = FWD_WB;
    else if (sh_vld)                              sel = FWD_SHADOW;
  end

  // Data path driven by the select
  always_comb begin
    op_o = rf_q_i;
    case (sel)
      FWD_ZERO:   op_o = '0;
      FWD_EX:     op_o = ex_data_i;
      FWD_MEM:    op_o = mem_data_i;
      FWD_WB:     op_o = rf_dst_d_i;
      FWD_SHADOW: op_o = sh_data;
      default:    op_o = rf_q_i;
    endcase
  end

  assign src_o = src_q;
  assign use_o = use_q;

endmodule

// File: rtl/riscv_id_operand_fetch.sv
// ID operand-fetch stage: merges synchronous RF read data with EX/MEM/WB
// bypasses, detects load-use hazards and registers operands into EX.
module riscv_id_operand_fetch
  import riscv_opcodes_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pd_stall_i,
  input  logic            id_stall_i,
  input  logic            pd_valid_i,
  input  rsd_t            rf_src1_i,
  input  rsd_t            rf_src2_i,
  input  logic            use_rs1_i,
  input  logic            use_rs2_i,
  input  logic [XLEN-1:0] rf_src1_q_o,
  input  logic [XLEN-1:0] rf_src2_q_o,
  input  logic            ex_we_i,
  input  logic            ex_is_load_i,
  input  rsd_t            ex_dst_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            mem_we_i,
  input  rsd_t            mem_dst_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            rf_we_i,
  input  rsd_t            rf_dst_i,
  input  logic [XLEN-1:0] rf_dst_d_i,
  output logic [XLEN-1:0] ex_op1_o,
  output logic [XLEN-1:0] ex_op2_o,
  output logic            ex_valid_o,
  output logic            load_use_stall_o
);

  logic                          id_valid;
  logic                          sample;
  logic                          ex_fwd;
  rsd_t [NUM_OPS-1:0]            src_new, src_q;
  logic [NUM_OPS-1:0]            use_new, use_q, lu_hit;
  logic [NUM_OPS-1:0][XLEN-1:0]  rf_q, op;

  assign src_new = {rf_src2_i, rf_src1_i};
  assign use_new = {use_rs2_i, use_rs1_i};
  assign rf_q    = {rf_src2_q_o, rf_src1_q_o};
  assign sample  = ~pd_stall_i & ~load_use_stall_o;
  // A load's EX result is not data yet, so only non-loads bypass from EX
  assign ex_fwd  = ex_we_i & ~ex_is_load_i;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    riscv_operand_mux #(.XLEN(XLEN)) u_mux (
      .clk       (clk),
      .rst       (rst),
      .sample_i  (sample),
      .src_i     (src_new[g]),
      .use_i     (use_new[g]),
      .ex_fwd_i  (ex_fwd),
      .ex_dst_i  (ex_dst_i),
      .ex_data_i (ex_data_i),
      .mem_we_i  (mem_we_i),
      .mem_dst_i (mem_dst_i),
      .mem_data_i(mem_data_i),
      .rf_we_i   (rf_we_i),
      .rf_dst_i  (rf_dst_i),
      .rf_dst_d_i(rf_dst_d_i),
      .rf_q_i    (rf_q[g]),
      .src_o     (src_q[g]),
      .use_o     (use_q[g]),
      .op_o      (op[g])
    );
  end

  // Load in EX targeting a register the ID instruction actually reads
  always_comb begin
    lu_hit = '0;
    for (int i = 0; i < NUM_OPS; i++)
      lu_hit[i] = use_q[i] && (ex_dst_i == src_q[i]);
    load_use_stall_o = id_valid && ex_we_i && ex_is_load_i &&
                       (ex_dst_i != zero) && (|lu_hit);
  end

  // ID valid bit follows the index sample
  always_ff @(posedge clk) begin
    if (rst)         id_valid <= 1'b0;
    else if (sample) id_valid <= pd_valid_i;
  end

  // EX operand registers: hold on ID stall, bubble on load-use
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_op1_o   <= '0;
      ex_op2_o   <= '0;
      ex_valid_o <= 1'b0;
    end else if (!id_stall_i) begin
      if (load_use_stall_o) begin
        ex_valid_o <= 1'b0;
      end else begin
        ex_op1_o   <= op[0];
        ex_op2_o   <= op[1];
        ex_valid_o <= id_valid;
      end
    end
  end

endmodule

// File: tb/tb_riscv_id_operand_fetch.sv
// Randomized and directed bench for riscv_id_operand_fetch. The reference
// treats an operand as the architectural register value seen by ID:
// newest in-flight producer, else the committed register array.
module tb_riscv_id_operand_fetch;
  import riscv_opcodes_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            pd_stall_i, id_stall_i, pd_valid_i;
  rsd_t            rf_src1_i, rf_src2_i;
  logic            use_rs1_i, use_rs2_i;
  logic [XLEN-1:0] rf_src1_q_o, rf_src2_q_o;
  logic            ex_we_i, ex_is_load_i;
  rsd_t            ex_dst_i;
  logic [XLEN-1:0] ex_data_i;
  logic            mem_we_i;
  rsd_t            mem_dst_i;
  logic [XLEN-1:0] mem_data_i;
  logic            rf_we_i;
  rsd_t            rf_dst_i;
  logic [XLEN-1:0] rf_dst_d_i;
  logic [XLEN-1:0] ex_op1_o, ex_op2_o;
  logic            ex_valid_o, load_use_stall_o;

  always #5 clk = ~clk;

  riscv_id_operand_fetch #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .pd_stall_i(pd_stall_i), .id_stall_i(id_stall_i),
    .pd_valid_i(pd_valid_i), .rf_src1_i(rf_src1_i), .rf_src2_i(rf_src2_i),
    .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i),
    .rf_src1_q_o(rf_src1_q_o), .rf_src2_q_o(rf_src2_q_o),
    .ex_we_i(ex_we_i), .ex_is_load_i(ex_is_load_i), .ex_dst_i(ex_dst_i),
    .ex_data_i(ex_data_i), .mem_we_i(mem_we_i), .mem_dst_i(mem_dst_i),
    .mem_data_i(mem_data_i), .rf_we_i(rf_we_i), .rf_dst_i(rf_dst_i),
    .rf_dst_d_i(rf_dst_d_i), .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o),
    .ex_valid_o(ex_valid_o), .load_use_stall_o(load_use_stall_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference state: architectural registers plus what ID/EX should hold
  logic [31:0] regs [32];
  rsd_t        m_s1, m_s2;
  logic        m_u1, m_u2, m_idv, m_exv;
  logic [31:0] m_op1, m_op2;

  function automatic logic [31:0] ref_op(input rsd_t idx);
    if (idx == 5'd0)                                     return 32'd0;
    if (ex_we_i && !ex_is_load_i && ex_dst_i == idx)     return ex_data_i;
    if (mem_we_i && mem_dst_i == idx)                    return mem_data_i;
    if (rf_we_i && rf_dst_i == idx)                      return rf_dst_d_i;
    return regs[idx];
  endfunction

  function automatic logic ref_lu();
    return m_idv && ex_we_i && ex_is_load_i && ex_dst_i != 5'd0 &&
           ((m_u1 && ex_dst_i == m_s1) || (m_u2 && ex_dst_i == m_s2));
  endfunction

  // One clock: check the hazard output, advance the reference, check EX
  task automatic cyc();
    logic        lu, smp;
    logic [31:0] o1, o2, q1, q2;
    #1;
    lu = ref_lu();
    chk("load_use", 32'(load_use_stall_o), 32'(lu));
    o1  = ref_op(m_s1);
    o2  = ref_op(m_s2);
    smp = !pd_stall_i && !lu;
    q1  = regs[rf_src1_i];
    q2  = regs[rf_src2_i];
    @(posedge clk);
    #1;
    if (rst) begin
      m_s1 = 5'd0; m_s2 = 5'd0; m_u1 = 1'b0; m_u2 = 1'b0; m_idv = 1'b0;
      m_op1 = 32'd0; m_op2 = 32'd0; m_exv = 1'b0;
    end else begin
      if (!id_stall_i) begin
        if (lu) m_exv = 1'b0;
        else begin m_op1 = o1; m_op2 = o2; m_exv = m_idv; end
      end
      if (smp) begin
        m_s1 = rf_src1_i; m_s2 = rf_src2_i;
        m_u1 = use_rs1_i; m_u2 = use_rs2_i; m_idv = pd_valid_i;
      end
    end
    // Synchronous RF model: read data reflects pre-write contents at the sample
    if (smp) begin rf_src1_q_o = q1; rf_src2_q_o = q2; end
    if (rf_we_i && rf_dst_i != 5'd0) regs[rf_dst_i] = rf_dst_d_i;
    @(negedge clk);
    chk("ex_op1", ex_op1_o, m_op1);
    chk("ex_op2", ex_op2_o, m_op2);
    chk("ex_valid", 32'(ex_valid_o), 32'(m_exv));
  endtask

  task automatic idle();
    rst = 1'b0; pd_stall_i = 1'b0; id_stall_i = 1'b0; pd_valid_i = 1'b0;
    rf_src1_i = 5'd0; rf_src2_i = 5'd0; use_rs1_i = 1'b0; use_rs2_i = 1'b0;
    ex_we_i = 1'b0; ex_is_load_i = 1'b0; ex_dst_i = 5'd0; ex_data_i = 32'd0;
    mem_we_i = 1'b0; mem_dst_i = 5'd0; mem_data_i = 32'd0;
    rf_we_i = 1'b0; rf_dst_i = 5'd0; rf_dst_d_i = 32'd0;
  endtask

  task automatic wb(input rsd_t d, input logic [31:0] v);
    rf_we_i = 1'b1; rf_dst_i = d; rf_dst_d_i = v;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    m_s1 = 5'd0; m_s2 = 5'd0; m_u1 = 1'b0; m_u2 = 1'b0; m_idv = 1'b0;
    m_op1 = 32'd0; m_op2 = 32'd0; m_exv = 1'b0;
    rf_src1_q_o = 32'd0; rf_src2_q_o = 32'd0;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    cyc();                                   // reset values

    // Plain read of x5
    idle(); wb(5'd5, 32'h1234); cyc();
    idle(); pd_valid_i = 1'b1; rf_src1_i = 5'd5; use_rs1_i = 1'b1; cyc();
    idle(); cyc();
    chk("plain_op1", ex_op1_o, 32'h1234);
    chk("plain_vld", 32'(ex_valid_o), 32'd1);

    // Forward priority EX > MEM > WB on x7
    idle(); pd_valid_i = 1'b1; rf_src1_i = 5'd7; cyc();
    pd_stall_i = 1'b1;
    ex_we_i = 1'b1; ex_dst_i = 5'd7; ex_data_i = 32'hA;
    mem_we_i = 1'b1; mem_dst_i = 5'd7; mem_data_i = 32'hB;
    wb(5'd7, 32'hC); cyc();
    chk("fwd_ex", ex_op1_o, 32'hA);
    ex_we_i = 1'b0; cyc();
    chk("fwd_mem", ex_op1_o, 32'hB);

    // Shadow capture of x9 while ID is stalled
    idle(); wb(5'd9, 32'h11); cyc();
    idle(); pd_valid_i = 1'b1; rf_src2_i = 5'd9; use_rs2_i = 1'b1; cyc();
    idle(); pd_stall_i = 1'b1; id_stall_i = 1'b1; cyc();
    wb(5'd9, 32'h55); cyc();
    rf_we_i = 1'b0; cyc();
    id_stall_i = 1'b0; cyc();
    chk("shadow_op2", ex_op2_o, 32'h55);

    // Load-use on x3, then MEM forwarding of the load result
    idle(); pd_valid_i = 1'b1; rf_src1_i = 5'd3; use_rs1_i = 1'b1; cyc();
    ex_we_i = 1'b1; ex_is_load_i = 1'b1; ex_dst_i = 5'd3; ex_data_i = 32'hBAD;
    #1 chk("lu_hit", 32'(load_use_stall_o), 32'd1);
    cyc();
    chk("lu_bubble", 32'(ex_valid_o), 32'd0);
    ex_we_i = 1'b0; ex_is_load_i = 1'b0;
    mem_we_i = 1'b1; mem_dst_i = 5'd3; mem_data_i = 32'hDEAD; cyc();
    chk("lu_mem_op1", ex_op1_o, 32'hDEAD);
    chk("lu_mem_vld", 32'(ex_valid_o), 32'd1);

    // x0 is never forwarded and never a load-use source
    idle(); pd_valid_i = 1'b1; use_rs1_i = 1'b1; use_rs2_i = 1'b1; cyc();
    ex_we_i = 1'b1; ex_is_load_i = 1'b1; ex_dst_i = 5'd0; ex_data_i = 32'hFF;
    wb(5'd0, 32'hEE);
    #1 chk("x0_lu", 32'(load_use_stall_o), 32'd0);
    cyc();
    ex_is_load_i = 1'b0; cyc();
    chk("x0_op1", ex_op1_o, 32'd0);
    chk("x0_op2", ex_op2_o, 32'd0);

    // Reset while a shadow is held
    idle(); wb(5'd6, 32'h22); cyc();
    idle(); pd_valid_i = 1'b1; rf_src1_i = 5'd6; cyc();
    idle(); pd_stall_i = 1'b1; id_stall_i = 1'b1; wb(5'd6, 32'h77); cyc();
    rf_we_i = 1'b0; cyc();
    rst = 1'b1; cyc();
    chk("rst_op1", ex_op1_o, 32'd0);
    chk("rst_vld", 32'(ex_valid_o), 32'd0);
    idle(); pd_valid_i = 1'b1; rf_src1_i = 5'd6; cyc();
    idle(); cyc();
    chk("rst_reread", ex_op1_o, 32'h77);

    // Random traffic over a small register window to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 59) == 0);
      pd_stall_i   = ($urandom_range(0, 3) == 0);
      id_stall_i   = ($urandom_range(0, 3) == 0);
      pd_valid_i   = ($urandom_range(0, 3) != 0);
      rf_src1_i    = rsd_t'($urandom_range(0, 4));
      rf_src2_i    = rsd_t'($urandom_range(0, 4));
      use_rs1_i    = 1'($urandom);
      use_rs2_i    = 1'($urandom);
      ex_we_i      = 1'($urandom);
      ex_is_load_i = ($urandom_range(0, 2) == 0);
      ex_dst_i     = rsd_t'($urandom_range(0, 4));
      ex_data_i    = $urandom;
      mem_we_i     = 1'($urandom);
      mem_dst_i    = rsd_t'($urandom_range(0, 4));
      mem_data_i   = $urandom;
      rf_we_i      = 1'($urandom);
      rf_dst_i     = rsd_t'($urandom_range(0, 4));
      rf_dst_d_i   = $urandom;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
